// File: rtl/game_move.sv
// game_move: single-move Sokoban engine on a fixed 8x8 grid.
//
// Takes one direction command, computes the post-move state from the current 134-bit game state
// and presents both the before-move snapshot and the after-move state. One move in flight; a
// command is accepted only in IDLE and the result strobe follows two edges later.
//
// State word layout (all 134-bit ports):
//   [133:128] player position (row*8+col), [127:64] box map, [63:0] wall map.
//
// Ports:
//   clk_i            clock, rising edge
//   rst_i            synchronous active-high reset
//   game_state_i     current committed state, sampled on accept
//   target_map_i     goal cells of the loaded level
//   dir_i            00 up, 01 down, 10 left, 11 right
//   dir_valid_i      command request
//   ready_o          high in IDLE only
//   game_state_bm_o  snapshot of game_state_i at accept
//   game_state_mm_o  post-move state
//   move_done_o      one-cycle result strobe
//   move_ok_o        player moved (held until next move_done_o)
//   solved_o         every box sits on a target in game_state_mm_o (held)
//
// Optional feature, macro GAME_MOVE_STEP_CNT_EN:
//   step_clr_i       synchronous clear of the step counter
//   step_cnt_o       saturating count of successful moves
module game_move (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [133:0] game_state_i,
  input  logic [63:0]  target_map_i,
  input  logic [1:0]   dir_i,
  input  logic         dir_valid_i,
  output logic         ready_o,
  output logic [133:0] game_state_bm_o,
  output logic [133:0] game_state_mm_o,
  output logic         move_done_o,
  output logic         move_ok_o,
`ifdef GAME_MOVE_STEP_CNT_EN
  output logic         solved_o,
  input  logic         step_clr_i,
  output logic [9:0]   step_cnt_o
`else
  output logic         solved_o
`endif
);

  typedef enum logic [1:0] {StIdle, StAddr, StEval, StDone} state_e;

  state_e         state_q, state_d;
  logic [133:0]   bm_q, bm_d;
  logic [133:0]   mm_q, mm_d;
  logic [1:0]     dir_q, dir_d;
  logic [5:0]     p1_q, p1_d, p2_q, p2_d;
  logic           p1_off_q, p1_off_d, p2_off_q, p2_off_d;
  logic           ok_q, ok_d, solved_q, solved_d;

  logic           accept;
  logic [5:0]     delta;
  logic [5:0]     cur_pos;
  logic [63:0]    cur_boxes, cur_walls, new_boxes;

  // True when stepping from pos in direction d would leave the grid.
  function automatic logic edge_hit(input logic [5:0] pos, input logic [1:0] d);
    unique case (d)
      2'b00:   edge_hit = (pos[5:3] == 3'd0);
      2'b01:   edge_hit = (pos[5:3] == 3'd7);
      2'b10:   edge_hit = (pos[2:0] == 3'd0);
      default: edge_hit = (pos[2:0] == 3'd7);
    endcase
  endfunction

  assign accept    = dir_valid_i & (state_q == StIdle);
  assign cur_pos   = bm_q[133:128];
  assign cur_boxes = bm_q[127:64];
  assign cur_walls = bm_q[63:0];

  // Two's-complement deltas in 6 bits; wrapped results are masked by the edge flags.
  always_comb begin
    unique case (dir_q)
      2'b00:   delta = 6'd56;
      2'b01:   delta = 6'd8;
      2'b10:   delta = 6'd63;
      default: delta = 6'd1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    bm_d     = bm_q;
    dir_d    = dir_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    p1_off_d = p1_off_q;
    p2_off_d = p2_off_q;
    mm_d     = mm_q;
    ok_d     = ok_q;
    solved_d = solved_q;
    new_boxes = cur_boxes;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          bm_d    = game_state_i;
          dir_d   = dir_i;
          state_d = StAddr;
        end
      end
      StAddr: begin
        p1_d     = cur_pos + delta;
        p2_d     = cur_pos + delta + delta;
        p1_off_d = edge_hit(cur_pos, dir_q);
        // p2 is only reachable through p1, so p1 leaving the grid also rules out p2.
        p2_off_d = edge_hit(cur_pos, dir_q) | edge_hit(cur_pos + delta, dir_q);
        state_d  = StEval;
      end
      StEval: begin
        mm_d = bm_q;
        ok_d = 1'b0;
        if (!p1_off_q && !cur_walls[p1_q]) begin
          if (cur_boxes[p1_q]) begin
            if (!p2_off_q && !cur_walls[p2_q] && !cur_boxes[p2_q]) begin
              new_boxes[p1_q] = 1'b0;
              new_boxes[p2_q] = 1'b1;
              mm_d = {p1_q, new_boxes, cur_walls};
              ok_d = 1'b1;
            end
          end else begin
            mm_d = {p1_q, cur_boxes, cur_walls};
            ok_d = 1'b1;
          end
        end
        solved_d = ((mm_d[127:64] & ~target_map_i) == 64'd0);
        state_d  = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      bm_q     <= '0;
      mm_q     <= '0;
      dir_q    <= '0;
      p1_q     <= '0;
      p2_q     <= '0;
      p1_off_q <= 1'b0;
      p2_off_q <= 1'b0;
      ok_q     <= 1'b0;
      solved_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bm_q     <= bm_d;
      mm_q     <= mm_d;
      dir_q    <= dir_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      p1_off_q <= p1_off_d;
      p2_off_q <= p2_off_d;
      ok_q     <= ok_d;
      solved_q <= solved_d;
    end
  end

  assign ready_o         = (state_q == StIdle);
  assign move_done_o     = (state_q == StDone);
  assign game_state_bm_o = bm_q;
  assign game_state_mm_o = mm_q;
  assign move_ok_o       = ok_q;
  assign solved_o        = solved_q;

`ifdef GAME_MOVE_STEP_CNT_EN
  logic [9:0] step_cnt_q, step_cnt_d;

  always_comb begin
    step_cnt_d = step_cnt_q;
    if (step_clr_i) begin
      step_cnt_d = 10'd0;
    end else if ((state_q == StDone) && ok_q && (step_cnt_q != 10'd1023)) begin
      step_cnt_d = step_cnt_q + 10'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      step_cnt_q <= 10'd0;
    end else begin
      step_cnt_q <= step_cnt_d;
    end
  end

  assign step_cnt_o = step_cnt_q;
`endif

endmodule

// File: doc/game_move.md
# game_move

Move engine directly upstream of the retract/history stage. Accepts one direction command, computes the post-move Sokoban state from the current 134-bit game state, and presents both the before-move snapshot and the after-move state. These feed that stage's `game_state_bm` and `game_state_mm` inputs, with `move_done` driving its `game_state_en`. Multi-cycle FSM; one move in flight at a time.

## Interface

- State word layout, fixed for all 134-bit ports:
  - [133:128] player position, row*8+col on an 8x8 grid.
  - [127:64] box map, bit n = box at cell n.
  - [63:0] wall map.
- No parameters; grid is fixed 8x8.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `game_state` in 134: current committed state, sampled only on accept.
- `target_map` in 64: static goal cells of the loaded level.
- `dir` in 2: 00 up (-8), 01 down (+8), 10 left (-1), 11 right (+1).
- `dir_valid` in 1: command request.
- `ready` out 1: high only in IDLE; accept = `dir_valid & ready` at a rising edge.
- `game_state_bm` out 134: snapshot of `game_state` at accept.
- `game_state_mm` out 134: post-move state.
- `move_done` out 1: one-cycle strobe, results valid.
- `move_ok` out 1: 1 if player moved, valid with `move_done`, held until next `move_done`.
- `solved` out 1: all boxes on targets in `game_state_mm`, valid with `move_done`, held until next `move_done`.

## Operation

- FSM states: IDLE -> ADDR -> EVAL -> DONE -> IDLE; unconditional after accept.
- **IDLE**: on accept, register `game_state` into `game_state_bm` and latch `dir`. `dir_valid` outside IDLE is ignored, not queued.
- **ADDR**: compute p1 = pos+delta and p2 = pos+2*delta, with edge flags.
  - p1 is off-grid for: up with row==0; down with row==7; left with col==0; right with col==7.
  - p2 is off-grid under the same test applied from p1.
  - 6-bit arithmetic wrap must never be used as a valid cell.
- **EVAL**: decide the move and register the DONE-stage outputs.
  - p1 off-grid or wall: no move.
  - p1 box, and p2 off-grid, wall, or box: no move.
  - p1 box, p2 free: box bit p1 cleared, box bit p2 set, pos=p1.
  - p1 empty: pos=p1.
  - Wall map is always copied unchanged.
  - No move: `game_state_mm` = `game_state_bm`, `move_ok`=0.
  - `solved` = ((box map of mm & ~`target_map`) == 0).
- **DONE**: `move_done`=1 for this cycle only.
- Target cells do not block movement. A box may be pushed onto or off a target.

## Timing

- Accept at edge E0; `game_state_bm` valid after E0.
- ADDR after E0, EVAL after E1.
- `game_state_mm`, `move_ok` and `solved` update at E2, alongside entry to DONE. `move_done`=1 between E2 and E3.
- `ready`=0 from E0 to E3; back in IDLE after E3. Max throughput is one command per 4 cycles.
- `move_done` pulses for every accepted command, including blocked ones.
- Reset values: FSM=IDLE, `ready`=1, `game_state_bm`=0, `game_state_mm`=0, `move_done`=0, `move_ok`=0, `solved`=0.
- `rst` in any state aborts the move: no `move_done` is issued, and all outputs take reset values at that edge.
- `rst` and `dir_valid` on the same edge: reset wins, command dropped.
- `game_state` and `target_map` may change freely after E0. `target_map` must be stable from E1 to E2.

## Configuration

- `GAME_MOVE_STEP_CNT_EN` defined:
  - Adds output `step_cnt` [9:0], reset to 0.
  - Increments on the DONE cycle when `move_ok`=1.
  - Saturates at 1023.
  - Adds input `step_clr` [1], which forces 0 synchronously; `rst` has priority.
  - `step_clr` wins over an increment in the same cycle.
- Not defined: no counter logic and no `step_cnt`/`step_clr` ports. All other behaviour is identical.

## Test plan

- Empty step right: pos=9, no boxes/walls, dir=11 -> `move_done` at E2. mm pos=10, `move_ok`=1, `game_state_bm` == input state.
- Box push: pos=9, box at 10, dir=11 -> mm pos=10, box bit 10=0, bit 11=1, `move_ok`=1. With `target_map`=bit 11 only, `solved`=1.
- Blocked:
  - Wall at 10 -> mm==bm, `move_ok`=0.
  - Box at 10 with wall at 11 -> mm==bm, `move_ok`=0.
  - Box at 10 with box at 11 -> mm==bm, `move_ok`=0.
- Edges:
  - pos=7 right -> no move.
  - pos=56 down -> no move.
  - pos=6 with box at 7, right -> no move (p2 off-grid, not wrapped to 8).
- Handshake/reset:
  - `dir_valid` held high continuously -> exactly one accept per 4 cycles.
  - `rst` asserted in EVAL -> no `move_done`, `ready`=1 and all outputs 0 on the next cycle.
- With `GAME_MOVE_STEP_CNT_EN`:
  - 3 successful moves + 1 blocked move -> `step_cnt`=3.
  - `step_clr` -> 0.
  - 1100 successful moves -> 1023.
